// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: execute has priority, load returns
// wait in a small FIFO, and a busy scoreboard flags pending load targets.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard,
  output logic [31:0]     busy,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]      f_rd_q   [DEPTH];
  logic [4:0]      f_rd_d   [DEPTH];
  logic [XLEN-1:0] f_data_q [DEPTH];
  logic [XLEN-1:0] f_data_d [DEPTH];

  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic            wr_is_ld_q, wr_is_ld_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            push;
  logic            pop;
  logic            sel_v;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  always_comb begin
    ld_ready = !reset && (count_q < FULL);
    push     = ld_valid && ld_ready;
    pop      = !ex_valid && (count_q != '0);

    sel_v    = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    unique case (1'b1)
      ex_valid: begin
        sel_v    = 1'b1;
        sel_rd   = ex_rd;
        sel_data = ex_data;
      end
      pop: begin
        sel_v    = 1'b1;
        sel_rd   = f_rd_q[head_q];
        sel_data = f_data_q[head_q];
      end
      default: ;
    endcase

    f_rd_d   = f_rd_q;
    f_data_d = f_data_q;
    if (push) begin
      f_rd_d[tail_q]   = ld_rd;
      f_data_d[tail_q] = ld_data;
    end

    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase

    // Writes to x0 still consume the FIFO entry but never reach the regfile.
    wr_en_d    = sel_v && (sel_rd != 5'd0);
    wr_is_ld_d = pop;
    wr_addr_d  = sel_v ? sel_rd : wr_addr_q;
    wr_data_d  = sel_v ? sel_data : wr_data_q;

    // Clear on the committed load first so a same-cycle issue wins.
    busy_d = busy_q;
    if (wr_en_q && wr_is_ld_q)
      busy_d[wr_addr_q] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0))
      busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_is_ld_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_is_ld_q <= wr_is_ld_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    f_rd_q   <= f_rd_d;
    f_data_q <= f_data_d;
  end

  assign hazard  = busy_q[rs1] | busy_q[rs2];
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
